dec_scan: RTL and testbench



---
 rtl/dec_scan.sv | 102 ++++++++++
 tb/tb_dec_scan.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dec_scan.sv
// dec_scan: registered one-hot decoder with an auto-scan sequencer.
// Direct mode decodes a loaded index. Scan mode walks the select through
// positions 0..scan_last_i, holding each position for SCAN_DIV cycles.
// Optional macro DEC_ACTIVE_LOW_EN: when defined, out_o is one-cold (inverted).
// Reset and blank values follow the same polarity.
module dec_scan #(
  parameter int unsigned IN_W     = 4,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic                   mode_i,
  input  logic                   load_i,
  input  logic [IN_W-1:0]        in_i,
  input  logic [IN_W-1:0]        scan_last_i,
  output logic [(2**IN_W)-1:0]   out_o,
  output logic [IN_W-1:0]        idx_o,
  output logic                   step_o,
  output logic                   wrap_o
);

  localparam int unsigned OUT_W = 2 ** IN_W;
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

`ifdef DEC_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] OUT_INV = '1;
`else
  localparam logic [OUT_W-1:0] OUT_INV = '0;
`endif

  logic [OUT_W-1:0] out_q, out_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  // Next-state: mode-entry detection, divider, index sequencing and decode.
  always_comb begin
    idx_d  = idx_q;
    div_d  = div_q;
    mode_d = mode_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    out_d  = OUT_INV;
    if (en_i) begin
      mode_d = mode_i;
      if (mode_i) begin
        if (!mode_q) begin
          // Entering scan: restart at position 0 with a fresh dwell.
          idx_d = '0;
          div_d = '0;
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          step_d = 1'b1;
          // >= so that lowering the limit below idx wraps on the next step.
          if (idx_q >= scan_last_i) begin
            idx_d  = '0;
            wrap_d = 1'b1;
          end else begin
            idx_d = idx_q + IN_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end else begin
        div_d = '0;
        if (load_i) begin
          idx_d = in_i;
        end
      end
      out_d = (OUT_W'(1) << idx_d) ^ OUT_INV;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q  <= OUT_INV;
      idx_q  <= '0;
      div_q  <= '0;
      mode_q <= 1'b0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      div_q  <= div_d;
      mode_q <= mode_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign out_o  = out_q;
  assign idx_o  = idx_q;
  assign step_o = step_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan with IN_W=4, SCAN_DIV=4.
module tb_dec_scan;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic        mode_i;
  logic        load_i;
  logic [3:0]  in_i;
  logic [3:0]  scan_last_i;
  logic [15:0] out_o;
  logic [3:0]  idx_o;
  logic        step_o;
  logic        wrap_o;

  int n_cmp;
  int n_err;

  // Hand-derived scan sequence for scan_last=3, cycles 1..20 after entry.
  int exp_idx  [20] = '{0,0,0,1, 1,1,1,2, 2,2,2,3, 3,3,3,0, 0,0,0,1};
  int exp_step [20] = '{0,0,0,1, 0,0,0,1, 0,0,0,1, 0,0,0,1, 0,0,0,1};
  int exp_wrap [20] = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,1, 0,0,0,0};
  logic [15:0] exp_out [20] = '{16'h0001,16'h0001,16'h0001,16'h0002,
                                16'h0002,16'h0002,16'h0002,16'h0004,
                                16'h0004,16'h0004,16'h0004,16'h0008,
                                16'h0008,16'h0008,16'h0008,16'h0001,
                                16'h0001,16'h0001,16'h0001,16'h0002};

  dec_scan #(.IN_W(4), .SCAN_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .mode_i      (mode_i),
    .load_i      (load_i),
    .in_i        (in_i),
    .scan_last_i (scan_last_i),
    .out_o       (out_o),
    .idx_o       (idx_o),
    .step_o      (step_o),
    .wrap_o      (wrap_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected select value in the configured output polarity.
  function automatic logic [15:0] pol(input logic [15:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] o, input int ix,
                             input int st, input int wr);
    check({tag, ".out"},  32'(out_o),  32'(pol(o)));
    check({tag, ".idx"},  32'(idx_o),  32'(ix));
    check({tag, ".step"}, 32'(step_o), 32'(st));
    check({tag, ".wrap"}, 32'(wrap_o), 32'(wr));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; en_i = 1'b0; mode_i = 1'b0; load_i = 1'b0;
    in_i = 4'h0; scan_last_i = 4'h3;
    tick(2);
    check_state("reset", 16'h0000, 0, 0, 0);

    // Direct decode of 0xA, then hold with load low.
    rst_n = 1'b1; en_i = 1'b1; load_i = 1'b1; in_i = 4'hA;
    tick(1);
    check_state("load_a", 16'h0400, 10, 0, 0);
    load_i = 1'b0; in_i = 4'h3;
    tick(2);
    check_state("hold_a", 16'h0400, 10, 0, 0);

    // Scan entry and 20 cycles with scan_last=3.
    mode_i = 1'b1; load_i = 1'b1; in_i = 4'h9;
    tick(1);
    check_state("entry", 16'h0001, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check_state($sformatf("scan%0d", k + 1), exp_out[k], exp_idx[k], exp_step[k], exp_wrap[k]);
    end

    // Raise limit to 7, walk up to idx 6, then lower limit to 2 mid-dwell.
    scan_last_i = 4'h7;
    tick(20);
    check_state("to6", 16'h0040, 6, 1, 0);
    scan_last_i = 4'h2;
    tick(3);
    check_state("dwell6", 16'h0040, 6, 0, 0);
    tick(1);
    check_state("shrink_wrap", 16'h0001, 0, 1, 1);

    // Advance to idx 2, one cycle into its dwell, then blank.
    tick(9);
    check_state("at2", 16'h0004, 2, 0, 0);
    en_i = 1'b0;
    tick(1);
    check_state("blank", 16'h0000, 2, 0, 0);
    tick(3);
    check_state("blank_hold", 16'h0000, 2, 0, 0);
    en_i = 1'b1;
    tick(1);
    check_state("unblank", 16'h0004, 2, 0, 0);
    tick(1);
    check_state("unblank_div3", 16'h0004, 2, 0, 0);
    tick(1);
    check_state("unblank_wrap", 16'h0001, 0, 1, 1);

    // Synchronous reset mid-scan, then re-entry and scan_last=0.
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check_state("mid_reset", 16'h0000, 0, 0, 0);
    rst_n = 1'b1; scan_last_i = 4'h0;
    tick(1);
    check_state("reentry", 16'h0001, 0, 0, 0);
    tick(3);
    check_state("last0_dwell", 16'h0001, 0, 0, 0);
    tick(1);
    check_state("last0_wrap", 16'h0001, 0, 1, 1);
    tick(4);
    check_state("last0_wrap2", 16'h0001, 0, 1, 1);

    // Mode exit with simultaneous load of 0xF.
    mode_i = 1'b0; load_i = 1'b1; in_i = 4'hF;
    tick(1);
    check_state("exit_load", 16'h8000, 15, 0, 0);
    load_i = 1'b0;
    tick(2);
    check_state("exit_hold", 16'h8000, 15, 0, 0);

    // Mode exit without load keeps the last scan position.
    mode_i = 1'b1; scan_last_i = 4'h3;
    tick(1);
    check_state("entry2", 16'h0001, 0, 0, 0);
    tick(4);
    check_state("scan_to1", 16'h0002, 1, 1, 0);
    mode_i = 1'b0;
    tick(3);
    check_state("exit_hold_scan", 16'h0002, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
